// File: rtl/wb2sdrc_pkg.sv
// Shared encodings for the Wishbone memory tester: test modes, FSM states, cycle type.
package wb2sdrc_pkg;

    typedef enum logic [1:0] {
        MODE_WR    = 2'b00,
        MODE_RD    = 2'b01,
        MODE_WR_RD = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

endpackage

// File: rtl/wb_mem_tester.sv
// Wishbone classic master that writes and/or read-compares an incrementing pattern.
// Latency: first strobe the cycle after start; done_o one cycle after FIN.
// Backpressure: each transfer waits for wb_ack_i, aborting after 2^TO_W-1 ack-less cycles.
module wb_mem_tester
    import wb2sdrc_pkg::*;
#(
    parameter int dw   = 32,
    parameter int TO_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [29:0]      base_addr_i,
    input  logic [15:0]      len_i,
    input  logic [dw-1:0]    seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      err_cnt_o,
    output logic [29:0]      first_err_addr_o,
    output logic             timeout_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [29:0]      wb_addr_o,
    output logic [dw-1:0]    wb_dat_o,
    output logic [dw/8-1:0]  wb_sel_o,
    output logic [2:0]       wb_cti_o,
    input  logic [dw-1:0]    wb_dat_i,
    input  logic             wb_ack_i
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [29:0]         base_q, base_d;
    logic [15:0]         len_q, len_d;
    logic [dw-1:0]       seed_q, seed_d;
    logic [15:0]         k_q, k_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [29:0]         addr_q, addr_d;
    logic [dw-1:0]       dat_q, dat_d;
    logic [dw/8-1:0]     sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [29:0]         first_err_q, first_err_d;
    logic                timeout_q, timeout_d;

    logic [15:0]         k_nxt;
    logic [TO_W-1:0]     to_nxt;
    logic                last_xfer;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        len_d       = len_q;
        seed_d      = seed_q;
        k_d         = k_q;
        to_d        = to_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;

        k_nxt     = k_q + 16'd1;
        to_nxt    = to_q + TO_W'(1);
        last_xfer = (k_q == len_q - 16'd1);

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_e'(mode_i);
                    base_d      = base_addr_i;
                    len_d       = len_i;
                    seed_d      = seed_i;
                    k_d         = 16'd0;
                    to_d        = '0;
                    err_cnt_d   = 16'd0;
                    first_err_d = 30'd0;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                    if (len_i == 16'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        // Outputs are registered, so transfer 0 is launched from here.
                        cyc_d   = 1'b1;
                        sel_d   = '1;
                        addr_d  = base_addr_i;
                        dat_d   = seed_i;
                        if (mode_e'(mode_i) == MODE_RD) begin
                            state_d = ST_RD_REQ;
                            we_d    = 1'b0;
                        end else begin
                            state_d = ST_WR_REQ;
                            we_d    = 1'b1;
                        end
                    end
                end
            end

            ST_WR_REQ, ST_RD_REQ: begin
                if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = (state_q == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
                    if (state_q == ST_RD_REQ && wb_dat_i != dat_q) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = addr_q;
                        end
                    end
                end else begin
                    to_d = to_nxt;
                    // Abort when this ack-less cycle brings the count to terminal.
                    if (to_nxt == {TO_W{1'b1}}) begin
                        cyc_d     = 1'b0;
                        sel_d     = '0;
                        we_d      = 1'b0;
                        timeout_d = 1'b1;
                        state_d   = ST_FIN;
                    end
                end
            end

            ST_WR_GAP, ST_RD_GAP: begin
                to_d = '0;
                if (last_xfer) begin
                    if (state_q == ST_WR_GAP && mode_q == MODE_WR_RD) begin
                        k_d     = 16'd0;
                        cyc_d   = 1'b1;
                        sel_d   = '1;
                        we_d    = 1'b0;
                        addr_d  = base_q;
                        dat_d   = seed_q;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    k_d     = k_nxt;
                    cyc_d   = 1'b1;
                    sel_d   = '1;
                    we_d    = (state_q == ST_WR_GAP);
                    addr_d  = base_q + 30'(k_nxt);
                    dat_d   = seed_q + dw'(k_nxt);
                    state_d = (state_q == ST_WR_GAP) ? ST_WR_REQ : ST_RD_REQ;
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WR;
            base_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            k_q         <= '0;
            to_q        <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            k_q         <= k_d;
            to_q        <= to_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign timeout_o        = timeout_q;
    assign wb_cyc_o         = cyc_q;
    assign wb_stb_o         = cyc_q;
    assign wb_we_o          = we_q;
    assign wb_addr_o        = addr_q;
    assign wb_dat_o         = dat_q;
    assign wb_sel_o         = sel_q;
    assign wb_cti_o         = CTI_CLASSIC;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester against a 16-word behavioural Wishbone slave.
module tb_wb_mem_tester;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [29:0] base_addr_i;
    logic [15:0] len_i;
    logic [31:0] seed_i;
    logic        busy_o, done_o, timeout_o;
    logic [15:0] err_cnt_o;
    logic [29:0] first_err_addr_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    // Slave: ack once stb has waited ack_wait cycles; optional corrupted word.
    logic [31:0] mem [16];
    int          ack_wait;
    int          age;
    logic        corrupt_en;
    logic [3:0]  corrupt_idx;

    logic [29:0] log_addr [$];
    logic [31:0] log_dat  [$];
    logic        log_we   [$];
    int          done_cnt = 0;
    int          stb_cnt  = 0;
    int          cyc_cnt  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    assign wb_ack_i = wb_cyc_o && wb_stb_o && (age >= ack_wait);
    assign wb_dat_i = (corrupt_en && wb_addr_o[3:0] == corrupt_idx) ? 32'hDEADBEEF
                                                                     : mem[wb_addr_o[3:0]];

    wb_mem_tester #(.dw(32), .TO_W(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always @(posedge wb_clk_i) begin
        if (wb_stb_o && !wb_ack_i) age <= age + 1;
        else                       age <= 0;
    end

    always @(negedge wb_clk_i) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            log_addr.push_back(wb_addr_o);
            log_dat.push_back(wb_dat_o);
            log_we.push_back(wb_we_o);
            if (wb_we_o) mem[wb_addr_o[3:0]] = wb_dat_o;
        end
        if (done_o)   done_cnt++;
        if (wb_stb_o) stb_cnt++;
        if (wb_cyc_o) cyc_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle after the start edge.
    task automatic do_start(input logic [1:0] m, input logic [29:0] b,
                            input logic [15:0] l, input logic [31:0] s);
        @(negedge wb_clk_i);
        mode_i = m; base_addr_i = b; len_i = l; seed_i = s;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        mode_i = 2'b01; base_addr_i = 30'h2AAAAAAA; len_i = 16'd9; seed_i = 32'h5555AAAA;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (!done_o && i < budget) begin
            @(negedge wb_clk_i);
            i++;
        end
        chk(tag, done_o, 1'b1);
        repeat (2) @(negedge wb_clk_i);
    endtask

    int d0, s0, c0, l0;

    initial begin
        wb_rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; base_addr_i = '0;
        len_i = '0; seed_i = '0; ack_wait = 0; age = 0;
        corrupt_en = 1'b0; corrupt_idx = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        repeat (3) @(negedge wb_clk_i);
        chk("rst ctl", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, timeout_o, wb_sel_o, wb_cti_o}, 64'h0);
        chk("rst addr", wb_addr_o, 64'h0);
        chk("rst dat", wb_dat_o, 64'h0);
        chk("rst errs", {err_cnt_o, first_err_addr_o}, 64'h0);
        wb_rst_i = 1'b0;

        // Write pass then read pass over a correct memory.
        d0 = done_cnt; l0 = log_addr.size();
        do_start(2'b10, 30'h100, 16'd4, 32'hA5A50000);
        chk("m10 first cyc", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o}, 64'hF);
        chk("m10 first addr", wb_addr_o, 64'h100);
        chk("m10 first sel", wb_sel_o, 64'hF);
        wait_done("m10 done", 100);
        chk("m10 nxfer", log_addr.size() - l0, 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("m10 addr", log_addr[l0+i], 64'h100 + (i % 4));
            chk("m10 dat", log_dat[l0+i], 64'hA5A50000 + (i % 4));
            chk("m10 we", log_we[l0+i], (i < 4) ? 64'd1 : 64'd0);
        end
        chk("m10 errs", err_cnt_o, 64'd0);
        chk("m10 done cnt", done_cnt - d0, 64'd1);
        chk("m10 idle", {busy_o, wb_cyc_o, timeout_o}, 64'd0);

        // Read-compare with word 1 corrupted.
        corrupt_en = 1'b1; corrupt_idx = 4'd1;
        l0 = log_addr.size();
        do_start(2'b01, 30'h100, 16'd3, 32'hA5A50000);
        chk("m01 first we", {wb_cyc_o, wb_we_o}, 64'b10);
        wait_done("m01 done", 100);
        corrupt_en = 1'b0;
        chk("m01 nxfer", log_addr.size() - l0, 64'd3);
        chk("m01 errs", err_cnt_o, 64'd1);
        chk("m01 first err", first_err_addr_o, 64'h101);
        repeat (3) @(negedge wb_clk_i);
        chk("m01 err hold", {err_cnt_o, first_err_addr_o}, {16'd1, 30'h101});

        // Slave never acks: timeout after 15 strobe cycles.
        ack_wait = 1000;
        d0 = done_cnt; s0 = stb_cnt;
        do_start(2'b00, 30'h20, 16'd2, 32'h1);
        chk("to err clr", err_cnt_o, 64'd0);
        wait_done("to done", 60);
        chk("to stb cycles", stb_cnt - s0, 64'd15);
        chk("to flag", timeout_o, 64'd1);
        chk("to done cnt", done_cnt - d0, 64'd1);
        repeat (3) @(negedge wb_clk_i);
        chk("to sticky", timeout_o, 64'd1);

        // Ack on the terminal-count cycle wins.
        ack_wait = 14;
        s0 = stb_cnt; l0 = log_addr.size();
        do_start(2'b00, 30'h30, 16'd1, 32'h77);
        chk("tc to clr", timeout_o, 64'd0);
        wait_done("tc done", 60);
        chk("tc stb cycles", stb_cnt - s0, 64'd15);
        chk("tc no timeout", timeout_o, 64'd0);
        chk("tc nxfer", log_addr.size() - l0, 64'd1);
        ack_wait = 0;

        // Zero length: no bus cycle, done two cycles after start.
        d0 = done_cnt; c0 = cyc_cnt;
        do_start(2'b10, 30'h50, 16'd0, 32'h9);
        chk("len0 c1", {done_o, busy_o, wb_cyc_o}, 64'b010);
        @(negedge wb_clk_i);
        chk("len0 c2", {done_o, busy_o, wb_cyc_o}, 64'b100);
        repeat (3) @(negedge wb_clk_i);
        chk("len0 cyc", cyc_cnt - c0, 64'd0);
        chk("len0 done cnt", done_cnt - d0, 64'd1);

        // Address wraps at 2^30.
        l0 = log_addr.size();
        do_start(2'b00, 30'h3FFFFFFF, 16'd2, 32'hFFFFFFFF);
        wait_done("wrap done", 40);
        chk("wrap a0", log_addr[l0], 64'h3FFFFFFF);
        chk("wrap a1", log_addr[l0+1], 64'h0);
        chk("wrap d1", log_dat[l0+1], 64'h0);

        // Reserved mode behaves as write-only.
        l0 = log_addr.size();
        do_start(2'b11, 30'h8, 16'd1, 32'h1234);
        wait_done("m11 done", 40);
        chk("m11 xfer", {log_addr.size() - l0, 32'(log_we[l0])}, {32'd1, 32'd1});

        // Reset during the third write of eight.
        d0 = done_cnt;
        do_start(2'b00, 30'h40, 16'd8, 32'h1000);
        for (int i = 0; i < 40 && !(wb_cyc_o && wb_addr_o == 30'h42); i++) @(negedge wb_clk_i);
        chk("rst mid reached", {wb_cyc_o, wb_addr_o}, {1'b1, 30'h42});
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst mid ctl", {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, wb_sel_o}, 64'h0);
        chk("rst mid bus", {wb_addr_o, wb_dat_o}, 64'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst mid no done", done_cnt - d0, 64'd0);

        l0 = log_addr.size();
        do_start(2'b10, 30'h40, 16'd2, 32'h1000);
        wait_done("post rst done", 60);
        chk("post rst nxfer", log_addr.size() - l0, 64'd4);
        chk("post rst a0", {log_addr[l0], log_dat[l0]}, {30'h40, 32'h1000});
        chk("post rst a3", {log_addr[l0+3], log_dat[l0+3]}, {30'h41, 32'h1001});
        chk("post rst errs", err_cnt_o, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
